updown_counter_mod: RTL and testbench
=====================================

// Module: updown_counter_mod
// PURPOSE
// - Synchronous, parametrised modulo-N up/down counter. It is the successor to the 4-bit ripple up/down counter.
// - Single clock domain, with count enable, parallel load, an optional clock-enable prescaler and a wrap pulse.
// - Used as the general timing/event counter in the Verilog problems set; replaces per-bit ripple-clocked T flip-flops.
// PARAMETERS
// - WIDTH     4   count register width in bits (>=1)
// - MODULUS   16  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
// - PRESCALE  1   count advances once per PRESCALE enabled clocks; 1 = every enabled clock
// PORTS
// - clk       in   1      rising-edge clock, sole clock of the block
// - rst       in   1      reset, asynchronous, active-low
// - en        in   1      count enable; prescaler and counter advance only while high
// - up_down   in   1      1 = count up, 0 = count down; sampled each cycle
// - load      in   1      synchronous parallel load
// - load_val  in   WIDTH  value loaded when load=1
// - sat       in   1      saturate instead of wrap (present only with CNT_SAT_EN)
// - q         out  WIDTH  current count
// - at_zero   out  1      combinational: q == 0
// - at_max    out  1      combinational: q == MODULUS-1
// - wrap      out  1      registered one-cycle pulse: the last update wrapped
// BEHAVIOUR
// - Reset (rst=0, async): q=0, wrap=0, prescaler count=0. Outputs are valid immediately.
// - Priority per rising edge: load > step > hold.
// - Load:
//   - q <= min(load_val, MODULUS-1); wrap <= 0; prescaler cleared.
//   - load works regardless of en.
// - Step:
//   - Occurs when en=1 and prescaler tick=1.
//   - tick = (pre_cnt == PRESCALE-1). pre_cnt increments while en=1 and returns to 0 at the tick.
//   - With PRESCALE=1, tick is constant 1.
// - Up step: q==MODULUS-1 -> q<=0, wrap<=1; else q<=q+1, wrap<=0.
// - Down step: q==0 -> q<=MODULUS-1, wrap<=1; else q<=q-1, wrap<=0.
// - Hold (en=0 or no tick): q unchanged; wrap<=0; pre_cnt frozen while en=0.
// - Latency: q and wrap both reflect an edge's step on the same edge (1 clk after the inputs are sampled).
// - Direction change: takes effect on the next step. No glitch, no extra cycle. q is never outside 0..MODULUS-1.
// - All arithmetic is modulo MODULUS, never modulo 2**WIDTH (e.g. MODULUS=10 never shows 10..15).
// - Reset asserted mid-count: immediate clear. Stepping resumes on the first enabled edge after rst deasserts.
// CONFIGURATION
// - Macro CNT_SAT_EN, when defined:
//   - adds port sat.
//   - With sat=1, an up step at MODULUS-1 holds at MODULUS-1 and a down step at 0 holds at 0; wrap stays 0.
//   - With sat=0, behaviour is identical to the undefined case.
// - Without CNT_SAT_EN: port absent; the counter always wraps.
// STRUCTURE
// - Package cnt_pkg:
//   - localparams DIR_UP=1'b1 and DIR_DN=1'b0;
//   - function clog2 used to size pre_cnt (width clog2(PRESCALE), minimum 1).
// - Sub-module cnt_prescaler (PRESCALE; clk, rst, en, clr -> tick):
//   - instantiated in updown_counter_mod;
//   - clr driven by load.
// - Top holds the q/wrap registers, the next-state mux, the flags and the CNT_SAT_EN guards.
// TESTING (WIDTH=4, MODULUS=10, PRESCALE=1 unless noted)
// - Reset: rst=0 while en=1 -> q=0, wrap=0, at_zero=1. Release rst; 3 up steps -> q=1,2,3.
// - Up wrap: from q=0, 10 enabled up clocks -> q=1..9 then 0; wrap=1 only in the cycle q returns to 0.
// - Down wrap and turnaround: load 2, up_down=0 -> q=1,0,9 with wrap at 9; then up_down=1 -> q=0, wrap=1.
// - Load and clamp: load_val=7 with en=1 -> q=7 (load wins); load_val=13 -> q=9; en=0, 5 clocks -> q stays 9.
// - Prescaler (PRESCALE=3): en=1 for 9 clocks -> q steps 0->1->2->3 on clocks 3,6,9; en=0 mid-period freezes the phase.
// - CNT_SAT_EN: sat=1, q=9, up -> q stays 9, wrap=0; q=0, down -> stays 0; rst pulse mid-count -> q=0 immediately.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter.
// Direction encodings and a log2 helper for sizing the prescaler.
package cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle for updown_counter_mod.
// Port sat exists only when CNT_SAT_EN is defined.
interface updown_counter_mod_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_val;
`ifdef CNT_SAT_EN
    logic             sat;
`endif
    logic [WIDTH-1:0] q;
    logic             at_zero;
    logic             at_max;
    logic             wrap;

    modport master (
        output en, up_down, load, load_val,
`ifdef CNT_SAT_EN
        output sat,
`endif
        input  q, at_zero, at_max, wrap
    );

    modport slave (
        input  en, up_down, load, load_val,
`ifdef CNT_SAT_EN
        input  sat,
`endif
        output q, at_zero, at_max, wrap
    );

endinterface

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: tick once every PRESCALE enabled clocks.
// Phase freezes while en=0; clr restarts the period.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // With PRESCALE=1 the count never leaves 0, so tick stays high.
    assign tick = (pre_cnt == LAST);

    // Phase counter: clears on load, advances only while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Modulo-MODULUS up/down counter with load, prescaler and wrap pulse.
// Optional macro CNT_SAT_EN adds a sat input that saturates at the ends.
module updown_counter_mod
    import cnt_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic rst,
    updown_counter_mod_if.slave bus
);

    localparam logic [WIDTH-1:0] MAXQ = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MAXW = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_n;
    logic             wrap_r;
    logic             wrap_n;
    logic             tick;
    logic             step;
    logic             do_up;
    logic             do_dn;
    logic             wrap_ok;
    logic [WIDTH-1:0] ld_clamp;

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (tick)
    );

`ifdef CNT_SAT_EN
    assign wrap_ok = ~bus.sat;
`else
    assign wrap_ok = 1'b1;
`endif

    assign step  = bus.en & tick;
    assign do_up = step & ~bus.load & (bus.up_down == DIR_UP);
    assign do_dn = step & ~bus.load & (bus.up_down == DIR_DN);

    // Load values beyond the range clamp to MODULUS-1.
    assign ld_clamp = ({1'b0, bus.load_val} > MAXW) ? MAXQ : bus.load_val;

    // Next count and wrap: load beats step beats hold.
    always_comb begin
        q_n    = q_r;
        wrap_n = 1'b0;
        unique case (1'b1)
            bus.load: begin
                q_n = ld_clamp;
            end
            do_up: begin
                if (q_r == MAXQ) begin
                    if (wrap_ok) begin
                        q_n    = '0;
                        wrap_n = 1'b1;
                    end
                end else begin
                    q_n = q_r + WIDTH'(1);
                end
            end
            do_dn: begin
                if (q_r == '0) begin
                    if (wrap_ok) begin
                        q_n    = MAXQ;
                        wrap_n = 1'b1;
                    end
                end else begin
                    q_n = q_r - WIDTH'(1);
                end
            end
            default: begin
                q_n    = q_r;
                wrap_n = 1'b0;
            end
        endcase
    end

    // Count and wrap registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_n;
            wrap_r <= wrap_n;
        end
    end

    assign bus.q       = q_r;
    assign bus.wrap    = wrap_r;
    assign bus.at_zero = (q_r == '0);
    assign bus.at_max  = (q_r == MAXQ);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: MODULUS=10 with PRESCALE=1 and 3.
// Sat checks run only when CNT_SAT_EN is defined.
module tb_updown_counter_mod;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_b = 1'b1;
    logic       ud_b = 1'b1;
    logic       ld_b = 1'b0;
    logic [3:0] lv_b = 4'd0;
    logic       sat_b = 1'b0;

    int errors = 0;
    int checks = 0;

    int mq[2]   = '{0, 0};
    int mpre[2] = '{0, 0};
    bit mw[2]   = '{1'b0, 1'b0};

    updown_counter_mod_if #(.WIDTH(4)) if0 ();
    updown_counter_mod_if #(.WIDTH(4)) if1 ();

    assign if0.en       = en_b;
    assign if0.up_down  = ud_b;
    assign if0.load     = ld_b;
    assign if0.load_val = lv_b;
    assign if1.en       = en_b;
    assign if1.up_down  = ud_b;
    assign if1.load     = ld_b;
    assign if1.load_val = lv_b;
`ifdef CNT_SAT_EN
    assign if0.sat = sat_b;
    assign if1.sat = sat_b;
`endif

    updown_counter_mod #(.WIDTH(4), .MODULUS(M), .PRESCALE(1)) d0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(M), .PRESCALE(3)) d1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Model: count as plain integers modulo M.
    function automatic void mstep(input int i, input int p);
        bit sa;
`ifdef CNT_SAT_EN
        sa = sat_b;
`else
        sa = 1'b0;
`endif
        mw[i] = 1'b0;
        if (ld_b) begin
            mq[i]   = (int'(lv_b) > M - 1) ? M - 1 : int'(lv_b);
            mpre[i] = 0;
        end else if (en_b) begin
            if (mpre[i] + 1 < p) begin
                mpre[i] = mpre[i] + 1;
            end else begin
                mpre[i] = 0;
                if (ud_b) begin
                    if (!(sa && mq[i] == M - 1)) begin
                        mw[i] = (mq[i] + 1 == M);
                        mq[i] = (mq[i] + 1) % M;
                    end
                end else begin
                    if (!(sa && mq[i] == 0)) begin
                        mw[i] = (mq[i] == 0);
                        mq[i] = (mq[i] + M - 1) % M;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i] = 0;
                mpre[i] = 0;
                mw[i] = 1'b0;
            end
        end else begin
            mstep(0, 1);
            mstep(1, 3);
        end
    end

    // Every falling edge: both DUTs against the model.
    always @(negedge clk) begin
        chk("m0_q", int'(if0.q), mq[0]);
        chk("m0_wrap", int'(if0.wrap), int'(mw[0]));
        chk("m0_zero", int'(if0.at_zero), int'(mq[0] == 0));
        chk("m0_max", int'(if0.at_max), int'(mq[0] == M - 1));
        chk("m1_q", int'(if1.q), mq[1]);
        chk("m1_wrap", int'(if1.wrap), int'(mw[1]));
        chk("m1_zero", int'(if1.at_zero), int'(mq[1] == 0));
        chk("m1_max", int'(if1.at_max), int'(mq[1] == M - 1));
    end

    int exp_pre[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

    initial begin
        #1;
        chk("rst_q", int'(if0.q), 0);
        chk("rst_wrap", int'(if0.wrap), 0);
        chk("rst_zero", int'(if0.at_zero), 1);
        cyc();
        cyc();
        chk("rst_hold_q", int'(if0.q), 0);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("rel_q", int'(if0.q), i);
        end

        ld_b = 1'b1;
        lv_b = 4'd0;
        cyc();
        ld_b = 1'b0;
        chk("ld0_q", int'(if0.q), 0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("upw_q", int'(if0.q), i % 10);
            chk("upw_wrap", int'(if0.wrap), (i == 10) ? 1 : 0);
        end
        chk("upw_zero", int'(if0.at_zero), 1);

        ld_b = 1'b1;
        lv_b = 4'd2;
        cyc();
        ld_b = 1'b0;
        ud_b = 1'b0;
        chk("ld2_q", int'(if0.q), 2);
        cyc();
        chk("dn1_q", int'(if0.q), 1);
        cyc();
        chk("dn0_q", int'(if0.q), 0);
        chk("dn0_wrap", int'(if0.wrap), 0);
        cyc();
        chk("dn9_q", int'(if0.q), 9);
        chk("dn9_wrap", int'(if0.wrap), 1);
        chk("dn9_max", int'(if0.at_max), 1);
        ud_b = 1'b1;
        cyc();
        chk("turn_q", int'(if0.q), 0);
        chk("turn_wrap", int'(if0.wrap), 1);

        ld_b = 1'b1;
        lv_b = 4'd7;
        cyc();
        chk("ld7_q", int'(if0.q), 7);
        lv_b = 4'd13;
        cyc();
        chk("ld13_q", int'(if0.q), 9);
        ld_b = 1'b0;
        en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("hold_q", int'(if0.q), 9);
            chk("hold_wrap", int'(if0.wrap), 0);
        end

        ld_b = 1'b1;
        lv_b = 4'd0;
        cyc();
        ld_b = 1'b0;
        en_b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("pre_q", int'(if1.q), exp_pre[i]);
        end
        cyc();
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_q", int'(if1.q), 3);
        end
        en_b = 1'b1;
        cyc();
        chk("frz2_q", int'(if1.q), 3);
        cyc();
        chk("frz3_q", int'(if1.q), 4);

`ifdef CNT_SAT_EN
        sat_b = 1'b1;
        ld_b = 1'b1;
        lv_b = 4'd9;
        cyc();
        ld_b = 1'b0;
        cyc();
        chk("sat_up_q", int'(if0.q), 9);
        chk("sat_up_wrap", int'(if0.wrap), 0);
        ld_b = 1'b1;
        lv_b = 4'd0;
        cyc();
        ld_b = 1'b0;
        ud_b = 1'b0;
        cyc();
        chk("sat_dn_q", int'(if0.q), 0);
        chk("sat_dn_wrap", int'(if0.wrap), 0);
        sat_b = 1'b0;
        ud_b = 1'b1;
`endif

        ld_b = 1'b1;
        lv_b = 4'd5;
        cyc();
        ld_b = 1'b0;
        cyc();
        chk("mid_q", int'(if0.q), 6);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_q0", int'(if0.q), 0);
        chk("arst_q1", int'(if1.q), 0);
        chk("arst_wrap", int'(if0.wrap), 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("resume_q", int'(if0.q), 1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
